// File: rtl/tama_button_ctrl_if.sv
// Command handshake between the button conditioner (master) and the pet FSM (slave).
// cmd_code is only meaningful while cmd_valid is high.
interface tama_button_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/tama_button_ctrl.sv
// Syncs + debounces four buttons, emits one command per press; 2 + DEBOUNCE_CYCLES edges to cmd_valid.
// One command held until cmd_ready, then cooldown; presses while busy are dropped and flag ovf.
module tama_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [3:0]                 btn_in,
  input  logic                       clr_ovf,
  tama_button_ctrl_if.master         cmd,
  output logic [3:0]                 btn_level,
  output logic                       busy,
  output logic                       ovf
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CDW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PENDING, COOLDOWN} state_t;

  state_t              state;
  logic [3:0]          s1, s2;
  logic [3:0][DBW-1:0] db_cnt, cnt_nxt;
  logic [3:0]          lvl_nxt, rise;
  logic [1:0]          win_code;
  logic                multi, drop;
  logic [CDW-1:0]      cd_cnt;

  // Press events are taken from the next level so the FSM reacts on the same edge as the flip.
  always_comb begin
    lvl_nxt = btn_level;
    cnt_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      if (s2[i] != btn_level[i]) begin
        if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) lvl_nxt[i] = s2[i];
        else                                        cnt_nxt[i] = db_cnt[i] + DBW'(1);
      end
    end
  end

  assign rise  = lvl_nxt & ~btn_level;
  assign multi = |(rise & (rise - 4'd1));
  assign drop  = ena && (|rise) && ((state != IDLE) || multi);

  always_comb begin
    win_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) win_code = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1            <= '0;
      s2            <= '0;
      btn_level     <= '0;
      db_cnt        <= '0;
      state         <= IDLE;
      cd_cnt        <= '0;
      busy          <= 1'b0;
      ovf           <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_code  <= 2'd0;
    end else begin
      s1        <= btn_in;
      s2        <= s1;
      btn_level <= lvl_nxt;
      db_cnt    <= cnt_nxt;

      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;

      case (state)
        IDLE: begin
          if (ena && (|rise)) begin
            state         <= PENDING;
            busy          <= 1'b1;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_code  <= win_code;
          end
        end
        PENDING: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            if (COOLDOWN_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= COOLDOWN;
              cd_cnt <= CDW'(COOLDOWN_CYCLES);
            end
          end
        end
        COOLDOWN: begin
          cd_cnt <= cd_cnt - CDW'(1);
          if (cd_cnt == CDW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tama_button_ctrl.sv
// Directed bench for tama_button_ctrl with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.
module tb_tama_button_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn_in;
  logic       clr_ovf;
  logic [3:0] btn_level;
  logic       busy;
  logic       ovf;
  int         n_cmp = 0;
  int         n_err = 0;

  tama_button_ctrl_if cif ();

  tama_button_ctrl #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .btn_in    (btn_in),
    .clr_ovf   (clr_ovf),
    .cmd       (cif),
    .btn_level (btn_level),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic handshake();
    cif.cmd_ready = 1'b1;
    cyc(1);
    cif.cmd_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    ena           = 1'b1;
    btn_in        = 4'hF;
    clr_ovf       = 1'b0;
    cif.cmd_ready = 1'b0;

    // Reset with all buttons pressed
    cyc(3);
    check("rst_valid", 32'(cif.cmd_valid), 32'd0);
    check("rst_code",  32'(cif.cmd_code),  32'd0);
    check("rst_level", 32'(btn_level),     32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_ovf",   32'(ovf),           32'd0);
    rst_n = 1'b1;
    cyc(5);
    check("rst_lvl_e5",   32'(btn_level),     32'd0);
    check("rst_valid_e5", 32'(cif.cmd_valid), 32'd0);
    cyc(1);
    check("rst_lvl_e6",   32'(btn_level),     32'hF);
    check("rst_valid_e6", 32'(cif.cmd_valid), 32'd1);
    check("rst_code_e6",  32'(cif.cmd_code),  32'd0);
    check("rst_ovf_e6",   32'(ovf),           32'd1);
    check("rst_busy_e6",  32'(busy),          32'd1);
    handshake();
    btn_in = 4'h0;
    check("rst_hs_valid", 32'(cif.cmd_valid), 32'd0);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    cyc(20);
    check("idle_ovf",   32'(ovf),       32'd0);
    check("idle_busy",  32'(busy),      32'd0);
    check("idle_level", 32'(btn_level), 32'd0);

    // Single press on bit2, command held without ready
    btn_in = 4'b0100;
    cyc(5);
    check("sp_valid_e4", 32'(cif.cmd_valid), 32'd0);
    cyc(1);
    check("sp_valid_e5", 32'(cif.cmd_valid), 32'd1);
    check("sp_code_e5",  32'(cif.cmd_code),  32'd2);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("sp_hold_valid", 32'(cif.cmd_valid), 32'd1);
      check("sp_hold_code",  32'(cif.cmd_code),  32'd2);
    end
    handshake();
    btn_in = 4'h0;
    check("sp_hs_valid", 32'(cif.cmd_valid), 32'd0);
    check("sp_hs_busy",  32'(busy),          32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check("sp_cool_busy", 32'(busy), 32'd1);
    end
    cyc(1);
    check("sp_cool_end", 32'(busy), 32'd0);

    // Short glitch on bit1
    cyc(4);
    btn_in = 4'b0010;
    cyc(3);
    btn_in = 4'h0;
    cyc(10);
    check("gl_level", 32'(btn_level),     32'd0);
    check("gl_valid", 32'(cif.cmd_valid), 32'd0);
    check("gl_ovf",   32'(ovf),           32'd0);

    // Press during cooldown is dropped
    btn_in = 4'b0001;
    cyc(6);
    check("bd_valid", 32'(cif.cmd_valid), 32'd1);
    check("bd_code",  32'(cif.cmd_code),  32'd0);
    handshake();
    btn_in = 4'b1000;
    cyc(10);
    check("bd_no_cmd", 32'(cif.cmd_valid), 32'd0);
    check("bd_ovf",    32'(ovf),           32'd1);
    cyc(10);
    check("bd_held_no_cmd", 32'(cif.cmd_valid), 32'd0);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("bd_clr_ovf", 32'(ovf), 32'd0);
    btn_in = 4'h0;
    cyc(20);

    // Simultaneous bits 1 and 3, then held
    btn_in = 4'b1010;
    cyc(6);
    check("sim_valid", 32'(cif.cmd_valid), 32'd1);
    check("sim_code",  32'(cif.cmd_code),  32'd1);
    check("sim_ovf",   32'(ovf),           32'd1);
    handshake();
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      check("sim_held_valid", 32'(cif.cmd_valid), 32'd0);
    end
    btn_in = 4'h0;
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    cyc(20);

    // Disabled press, then enable while held
    ena    = 1'b0;
    btn_in = 4'b0001;
    cyc(10);
    check("en_off_valid", 32'(cif.cmd_valid), 32'd0);
    check("en_off_ovf",   32'(ovf),           32'd0);
    check("en_off_level", 32'(btn_level),     32'd1);
    ena = 1'b1;
    cyc(10);
    check("en_on_valid", 32'(cif.cmd_valid), 32'd0);
    check("en_on_busy",  32'(busy),          32'd0);
    btn_in = 4'h0;
    cyc(10);

    // Reset while a command is pending discards it
    btn_in = 4'b0100;
    cyc(6);
    check("mr_valid", 32'(cif.cmd_valid), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    check("mr_valid_rst", 32'(cif.cmd_valid), 32'd0);
    check("mr_busy_rst",  32'(busy),          32'd0);
    check("mr_level_rst", 32'(btn_level),     32'd0);
    btn_in = 4'h0;
    rst_n  = 1'b1;
    cyc(10);
    check("mr_after", 32'(cif.cmd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tama_button_ctrl.md
# tama_button_ctrl

Input-side conditioner for the tamagotchi pet core. It takes the four raw, asynchronous push-button inputs from `ui_in[3:0]`, synchronises and debounces each one, and turns each press into a single command code. It hands one command at a time to the pet state machine over a valid/ready handshake. A cooldown window after each accepted command rate-limits user actions; presses that arrive while a command is pending or during cooldown are dropped and flagged.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles (≥1) required to accept a level change.
- `COOLDOWN_CYCLES`, 64: cycles (≥0) after an accepted command during which presses are ignored.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: design enable; when low, new presses are ignored (debouncers keep running).
- `btn_in` in 4: raw buttons, active-high; bit0 feed, bit1 play, bit2 sleep, bit3 clean.
- `cmd_ready` in 1: pet FSM accepts the command this cycle.
- `clr_ovf` in 1: clears `ovf` (one-cycle strobe).
- `cmd_valid` out 1: command pending.
- `cmd_code` out 2: index of the pressed button; stable while `cmd_valid` is high.
- `btn_level` out 4: debounced button levels.
- `busy` out 1: high in the PENDING and COOLDOWN states.
- `ovf` out 1: sticky flag, set when a press is dropped.

## Operation
- Synchroniser: two flops per bit, `btn_in` → `s1` → `s2`.
- Debouncer, per bit:
  - Counter clears whenever `s2 == btn_level`.
  - Counter increments while `s2 != btn_level`.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`, `btn_level` takes `s2` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `btn_level`.
- Press event: a 0→1 flip of `btn_level[i]`, evaluated in the same cycle as the flip. Releases generate nothing.
- States:
  - IDLE → PENDING on any press event with `ena`=1. That edge loads `cmd_code` with the lowest-index pressing bit and sets `cmd_valid`.
  - PENDING → COOLDOWN on `cmd_valid && cmd_ready`. `cmd_valid` drops on that edge and the cooldown counter loads `COOLDOWN_CYCLES`. If `COOLDOWN_CYCLES`=0, go straight to IDLE.
  - COOLDOWN: the counter decrements each cycle. The state moves to IDLE on the edge where the counter goes 1→0.
- Drop rules; each sets `ovf`:
  - Press event in PENDING or COOLDOWN.
  - Extra simultaneous press events beyond the winner.
  - Presses with `ena`=0 are ignored silently and do not set `ovf`.
- `ovf`:
  - `clr_ovf` clears it.
  - If a set condition and `clr_ovf` occur in the same cycle, set wins.
- `cmd_valid` never deasserts without a handshake, and `cmd_code` never changes while valid, even if `ena` falls.

## Timing
- Reset (`rst_n`=0 at an edge): all outputs are 0 after that edge, state is IDLE, and all counters, synchronisers and `btn_level` are 0. Reset applied mid-PENDING discards the command.
- Press latency: raw rise set up before edge E0 gives `s2`=1 after E0+1. `btn_level`=1 and `cmd_valid`=1 follow after edge E0+1+`DEBOUNCE_CYCLES`.
- Handshake: the transfer happens on an edge where `cmd_valid`=1 and `cmd_ready`=1. `cmd_ready` may be high beforehand; it is not a combinational function of `cmd_valid`.
- The earliest next command is `COOLDOWN_CYCLES`+1 edges after the handshake edge. The press must produce its flip while in IDLE.
- A button held down produces exactly one command. It must be released (debounced) and pressed again to produce another.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `COOLDOWN_CYCLES`=8.

- **Reset:** hold `rst_n`=0 for 3 edges with `btn_in`=4'hF. All outputs are 0. Release reset; `btn_level`=4'hF and `cmd_valid`=1 with `cmd_code`=0 after edge 6, and `ovf`=1 (bits 1–3 dropped).
- **Single press:** `btn_in`=4'b0100 before E0 with `cmd_ready`=0. `cmd_valid`=1 and `cmd_code`=2 after E0+5. Both hold for 20 cycles. Pulse `cmd_ready`: `cmd_valid` drops on the next edge and `busy` stays 1 for 8 more edges.
- **Glitch:** `btn_in[1]` high for 3 cycles then low. `btn_level` and `cmd_valid` stay 0; `ovf`=0.
- **Busy drop:** bit0 press accepted. Press bit3 during cooldown. No second command, `ovf`=1. Assert `clr_ovf`; `ovf`=0 the next cycle.
- **Simultaneous and held:** `btn_in`=4'b1010 in the same cycle gives `cmd_code`=1 and `ovf`=1. Holding both for 100 cycles yields no further `cmd_valid`.
- **Enable:** `ena`=0, press bit0: no command and `ovf`=0. Set `ena`=1 while still held: no command, because the flip has already passed.
